// File: rtl/open_riscv_pkg.sv
// open_riscv_pkg: shared RV32I encodings and decode helpers.
//   - opcode / funct3 / funct7 constants
//   - ALU operation and writeback-source enums
//   - alu_decode(): maps funct3 plus the "alternate" bit (SUB/SRA) to an ALU op
package open_riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // alt selects SUB (funct3 000) or SRA/SRAI (funct3 101); ignored elsewhere
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/open_riscv_soc_if.sv
// open_riscv_soc_if: data-memory bus between core (master) and RAM (slave).
//   addr  : byte address
//   wdata : store data, already replicated into the target lanes
//   be    : byte-lane enables for stores
//   we    : store strobe, commits on the rising clock edge
//   rdata : combinational read of the addressed word
interface open_riscv_soc_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, wdata, be, we, input rdata);
  modport slave  (input addr, wdata, be, we, output rdata);
endinterface

// File: rtl/open_risc_v.sv
// open_risc_v: single-cycle RV32I core.
//   clk, rst : clock, synchronous active-high reset (pc <= RESET_PC, regs cleared)
//   o_pc     : fetch address to instruction ROM
//   i_instr  : instruction at o_pc (combinational)
//   dbus     : data bus master; loads read combinationally, stores commit on the edge
// Unsupported opcodes (FENCE, SYSTEM, unknown) retire as NOPs.
module open_risc_v
  import open_riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       o_pc,
  input  logic [31:0]       i_instr,
  open_riscv_soc_if.master  dbus
);
  logic [31:0] r_pc;

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_f3     = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_f7     = i_instr[31:25];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  logic [31:0] w_rs1_val, w_rs2_val, w_wd;
  logic        w_wb_en;

  regs regs_inst (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .i_we  (w_wb_en),
    .i_wa  (w_rd),
    .i_wd  (w_wd),
    .o_rd1 (w_rs1_val),
    .o_rd2 (w_rs2_val)
  );

  // branch comparator is separate from the ALU so both can be decoded in parallel
  logic w_eq, w_lt, w_ltu, w_br_taken;
  assign w_eq  = (w_rs1_val == w_rs2_val);
  assign w_lt  = ($signed(w_rs1_val) < $signed(w_rs2_val));
  assign w_ltu = (w_rs1_val < w_rs2_val);

  always_comb begin
    w_br_taken = 1'b0;
    case (w_f3)
      F3_BEQ:  w_br_taken = w_eq;
      F3_BNE:  w_br_taken = ~w_eq;
      F3_BLT:  w_br_taken = w_lt;
      F3_BGE:  w_br_taken = ~w_lt;
      F3_BLTU: w_br_taken = w_ltu;
      F3_BGEU: w_br_taken = ~w_ltu;
      default: w_br_taken = 1'b0;
    endcase
  end

  // dedicated adders keep next-pc and address paths off the ALU output
  logic [31:0] w_pc4, w_mem_addr, w_jalr_tgt;
  assign w_pc4      = r_pc + 32'd4;
  assign w_mem_addr = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
  assign w_jalr_tgt = (w_rs1_val + w_imm_i) & ~32'd1;

  alu_op_e     w_alu_op;
  wb_sel_e     w_wb_sel;
  logic [31:0] w_alu_a, w_alu_b, w_pc_next;
  logic        w_st_en;

  always_comb begin
    w_alu_op  = ALU_ADD;
    w_alu_a   = w_rs1_val;
    w_alu_b   = w_rs2_val;
    w_wb_en   = 1'b0;
    w_wb_sel  = WB_ALU;
    w_pc_next = w_pc4;
    w_st_en   = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_alu_op = ALU_PASSB;
        w_alu_b  = w_imm_u;
        w_wb_en  = 1'b1;
      end
      OP_AUIPC: begin
        w_alu_a = r_pc;
        w_alu_b = w_imm_u;
        w_wb_en = 1'b1;
      end
      OP_JAL: begin
        w_wb_en   = 1'b1;
        w_wb_sel  = WB_PC4;
        w_pc_next = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_f3 == 3'd0) begin
          w_wb_en   = 1'b1;
          w_wb_sel  = WB_PC4;
          w_pc_next = w_jalr_tgt;
        end
      end
      OP_BRANCH: begin
        if (w_br_taken) w_pc_next = r_pc + w_imm_b;
      end
      OP_LOAD: begin
        if (w_f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
          w_wb_en  = 1'b1;
          w_wb_sel = WB_MEM;
        end
      end
      OP_STORE: begin
        w_st_en = (w_f3 inside {F3_SB, F3_SH, F3_SW});
      end
      OP_IMM: begin
        // imm[10] is only an opcode bit for shifts; ADDI with a negative imm is not SUB
        w_alu_op = alu_decode(w_f3, (w_f3 == F3_SR) & i_instr[30]);
        w_alu_b  = w_imm_i;
        w_wb_en  = 1'b1;
      end
      OP_REG: begin
        w_alu_op = alu_decode(w_f3, w_f7 == F7_ALT);
        w_wb_en  = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: ;
    endcase
  end

  logic [31:0] w_alu_res;
  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD:   w_alu_res = w_alu_a + w_alu_b;
      ALU_SUB:   w_alu_res = w_alu_a - w_alu_b;
      ALU_SLL:   w_alu_res = w_alu_a << w_alu_b[4:0];
      ALU_SLT:   w_alu_res = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
      ALU_SLTU:  w_alu_res = {31'b0, w_alu_a < w_alu_b};
      ALU_XOR:   w_alu_res = w_alu_a ^ w_alu_b;
      ALU_SRL:   w_alu_res = w_alu_a >> w_alu_b[4:0];
      ALU_SRA:   w_alu_res = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
      ALU_OR:    w_alu_res = w_alu_a | w_alu_b;
      ALU_AND:   w_alu_res = w_alu_a & w_alu_b;
      ALU_PASSB: w_alu_res = w_alu_b;
      default:   w_alu_res = '0;
    endcase
  end

  // load lane select and extension
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;
  assign w_ld_byte = dbus.rdata[{w_mem_addr[1:0], 3'b000} +: 8];
  assign w_ld_half = w_mem_addr[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];

  always_comb begin
    w_ld_val = dbus.rdata;
    case (w_f3)
      F3_LB:   w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      F3_LH:   w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      F3_LBU:  w_ld_val = {24'b0, w_ld_byte};
      F3_LHU:  w_ld_val = {16'b0, w_ld_half};
      default: w_ld_val = dbus.rdata;
    endcase
  end

  always_comb begin
    w_wd = w_alu_res;
    case (w_wb_sel)
      WB_PC4:  w_wd = w_pc4;
      WB_MEM:  w_wd = w_ld_val;
      default: w_wd = w_alu_res;
    endcase
  end

  // store data is replicated across lanes; be picks which lanes commit
  assign dbus.addr = w_mem_addr;
  assign dbus.we   = w_st_en & ~rst;

  always_comb begin
    dbus.be    = 4'b0000;
    dbus.wdata = w_rs2_val;
    case (w_f3)
      F3_SB: begin
        dbus.be    = 4'b0001 << w_mem_addr[1:0];
        dbus.wdata = {4{w_rs2_val[7:0]}};
      end
      F3_SH: begin
        dbus.be    = w_mem_addr[1] ? 4'b1100 : 4'b0011;
        dbus.wdata = {2{w_rs2_val[15:0]}};
      end
      F3_SW:   dbus.be = 4'b1111;
      default: dbus.be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;
endmodule

// File: rtl/ram.sv
// ram: byte-addressed, word-organised data RAM built from four byte lanes.
//   clk : clock
//   bus : data bus slave; word index is addr[AW+1:2], be selects lanes
module ram #(
  parameter int DEPTH = 4096
) (
  input  logic             clk,
  open_riscv_soc_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]   w_idx;
  logic [3:0][7:0] w_wlane;
  logic [3:0][7:0] w_rlane;
  logic            w_unused;

  assign w_idx    = bus.addr[AW+1:2];
  assign w_wlane  = bus.wdata;
  assign w_unused = &{1'b0, bus.addr[31:AW+2], bus.addr[1:0]};

  for (genvar l = 0; l < 4; l++) begin : g_lane
    ram_lane #(.DEPTH(DEPTH), .AW(AW)) lane_inst (
      .clk     (clk),
      .i_we    (bus.we & bus.be[l]),
      .i_idx   (w_idx),
      .i_wdata (w_wlane[l]),
      .o_rdata (w_rlane[l])
    );
  end

  assign bus.rdata = w_rlane;
endmodule

// File: rtl/ram_lane.sv
// ram_lane: one byte lane of the data RAM.
//   clk     : clock
//   i_we    : write this lane at i_idx on the rising edge
//   i_idx   : word index
//   i_wdata : byte to store
//   o_rdata : combinational read of the byte at i_idx
module ram_lane #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/regs.sv
// regs: 32 x 32-bit integer register file.
//   clk, rst      : clock, synchronous active-high reset (clears all registers)
//   i_ra1/o_rd1   : read port 1 (combinational)
//   i_ra2/o_rd2   : read port 2 (combinational)
//   i_we/i_wa/i_wd: write port, commits on rising edge; x0 writes dropped
module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      regs[i_wa] <= i_wd;
    end
  end

  // no bypass: a same-cycle write is visible only after the edge
  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : regs[i_ra2];
endmodule

// File: rtl/rom.sv
// rom: instruction memory, combinational read.
//   i_addr : byte address (pc); low two bits ignored
//   o_data : instruction word rom_mem[i_addr[AW+1:2]]
// Contents are loaded from outside (hex image); no write port.
module rom #(
  parameter int DEPTH = 4096
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] rom_mem [0:DEPTH-1];
  logic        w_unused;

  assign w_unused = &{1'b0, i_addr[31:AW+2], i_addr[1:0]};
  assign o_data   = rom_mem[i_addr[AW+1:2]];
endmodule

// File: rtl/open_riscv_soc.sv
// open_riscv_soc: minimal RV32I SoC - single-cycle core, instruction ROM, data RAM.
//   clk : system clock, all state on the rising edge
//   rst : synchronous active-high reset
module open_riscv_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);
  logic [31:0] w_pc;
  logic [31:0] w_instr;

  open_riscv_soc_if dbus ();

  open_risc_v #(.RESET_PC(RESET_PC)) open_risc_v_inst (
    .clk     (clk),
    .rst     (rst),
    .o_pc    (w_pc),
    .i_instr (w_instr),
    .dbus    (dbus.master)
  );

  rom #(.DEPTH(ROM_DEPTH)) rom_inst (
    .i_addr (w_pc),
    .o_data (w_instr)
  );

  ram #(.DEPTH(RAM_DEPTH)) ram_inst (
    .clk (clk),
    .bus (dbus.slave)
  );
endmodule

// File: tb/tb_open_riscv_soc.sv
// Directed bench for open_riscv_soc: small hand-assembled programs are written
// into the ROM, run for a known number of cycles, and the register file / pc
// are compared with hand-computed values.
module tb_open_riscv_soc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ld_ptr   = 0;

  open_riscv_soc dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] ei(int op, int rd, int f3, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] es(int f3, int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(int op, int rd, int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] ad(int rd, int rs1, int imm);
    return ei(7'h13, rd, 0, rs1, imm);
  endfunction

  function automatic logic [31:0] rg(int i);
    return dut.open_risc_v_inst.regs_inst.regs[i];
  endfunction
  function automatic logic [31:0] pc();
    return dut.open_risc_v_inst.r_pc;
  endfunction

  task automatic clr_rom();
    for (int i = 0; i < 128; i++) dut.rom_inst.rom_mem[i] = 32'h0000_0013;
    ld_ptr = 0;
  endtask
  task automatic emit(input logic [31:0] w);
    dut.rom_inst.rom_mem[ld_ptr] = w;
    ld_ptr++;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- program 1: ALU, x0, immediates ----------------
    clr_rom();
    emit(ad(1, 0, 5));                 // 00
    emit(ad(2, 0, -3));                // 04
    emit(er(0, 2, 1, 0, 3));           // 08 add  x3,x1,x2
    emit(er(32, 1, 2, 0, 4));          // 0c sub  x4,x2,x1
    emit(er(0, 2, 1, 3, 5));           // 10 sltu x5,x1,x2
    emit(ei(7'h13, 6, 5, 2, 32'h401)); // 14 srai x6,x2,1
    emit(ad(0, 0, 7));                 // 18 addi x0,x0,7
    emit(eu(7'h37, 7, 20'h80000));     // 1c lui  x7,0x80000
    emit(eu(7'h17, 8, 1));             // 20 auipc x8,1
    emit(ad(7, 7, -1));                // 24
    emit(er(32, 1, 2, 5, 9));          // 28 sra  x9,x2,x1
    emit(er(0, 1, 2, 5, 10));          // 2c srl  x10,x2,x1
    emit(er(0, 1, 2, 2, 11));          // 30 slt  x11,x2,x1
    emit(ei(7'h13, 12, 2, 1, -1));     // 34 slti x12,x1,-1
    emit(ei(7'h13, 13, 3, 1, -1));     // 38 sltiu x13,x1,-1
    emit(ei(7'h13, 14, 4, 2, -1));     // 3c xori x14,x2,-1
    tick(2);
    chk("rst_pc", pc(), 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_x%0d", i), rg(i), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("first_x1", rg(1), 32'd5);
    chk("first_pc", pc(), 32'h4);
    tick(15);
    chk("alu_x2", rg(2), 32'hFFFF_FFFD);
    chk("alu_add", rg(3), 32'h2);
    chk("alu_sub", rg(4), 32'hFFFF_FFF8);
    chk("alu_sltu", rg(5), 32'h1);
    chk("alu_srai", rg(6), 32'hFFFF_FFFE);
    chk("x0_zero", rg(0), 32'h0);
    chk("lui_addi", rg(7), 32'h7FFF_FFFF);
    chk("auipc", rg(8), 32'h0000_1020);
    chk("alu_sra", rg(9), 32'hFFFF_FFFF);
    chk("alu_srl", rg(10), 32'h07FF_FFFF);
    chk("alu_slt", rg(11), 32'h1);
    chk("alu_slti", rg(12), 32'h0);
    chk("alu_sltiu", rg(13), 32'h1);
    chk("alu_xori", rg(14), 32'h2);
    chk("alu_pc", pc(), 32'h40);

    // mid-program reset clears live registers
    rst = 1'b1;
    tick(1);
    chk("rst2_pc", pc(), 32'h0);
    for (int i = 1; i < 15; i++) chk($sformatf("rst2_x%0d", i), rg(i), 32'h0);

    // ---------------- program 2: control flow ----------------
    clr_rom();
    emit(ad(2, 0, 1));           // 00
    emit(eb(1, 2, 0, 8));        // 04 bne x2,x0,+8 (taken)
    emit(ad(3, 0, 99));          // 08 skipped
    emit(ad(0, 0, 0));           // 0c
    emit(ej(1, 8));              // 10 jal x1,+8
    emit(ej(0, 12));             // 14 jal x0,+12
    emit(ad(1, 0, 21));          // 18 x1 = 0x15
    emit(ei(7'h67, 0, 0, 1, 0)); // 1c jalr x0,0(x1)
    emit(eb(0, 2, 0, 8));        // 20 beq x2,x0 (untaken)
    emit(ad(5, 0, 55));          // 24
    emit(eb(0, 0, 0, 8));        // 28 beq x0,x0 (taken)
    emit(ad(6, 0, 66));          // 2c skipped
    emit(eb(5, 0, 2, 8));        // 30 bge x0,x2 (untaken)
    emit(ad(7, 0, 77));          // 34
    emit(ad(8, 0, -1));          // 38
    emit(eb(4, 8, 0, 8));        // 3c blt x8,x0 (taken, signed)
    emit(ad(9, 0, 9));           // 40 skipped
    emit(eb(6, 8, 0, 8));        // 44 bltu x8,x0 (untaken, unsigned)
    emit(ad(10, 0, 10));         // 48
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("jal_pc", pc(), 32'h18);
    chk("jal_link", rg(1), 32'h14);
    chk("bne_skip", rg(3), 32'h0);
    tick(2);
    chk("jalr_pc", pc(), 32'h14);
    tick(10);
    chk("beq_fall", rg(5), 32'd55);
    chk("beq_taken", rg(6), 32'h0);
    chk("bge_fall", rg(7), 32'd77);
    chk("blt_taken", rg(9), 32'h0);
    chk("bltu_fall", rg(10), 32'd10);
    chk("jal_x0", rg(0), 32'h0);
    chk("cf_pc", pc(), 32'h4C);

    // ---------------- program 3: loads and stores ----------------
    rst = 1'b1;
    clr_rom();
    emit(eu(7'h37, 1, 20'h80000)); // 00
    emit(ad(1, 1, 255));           // 04 x1 = 0x800000FF
    emit(ad(2, 0, 256));           // 08 x2 = 0x100
    emit(es(2, 1, 2, 0));          // 0c sw  x1,0(x2)
    emit(ei(3, 3, 0, 2, 0));       // 10 lb  x3,0(x2)
    emit(ei(3, 4, 4, 2, 3));       // 14 lbu x4,3(x2)
    emit(ei(3, 5, 1, 2, 0));       // 18 lh  x5,0(x2)
    emit(ei(3, 6, 2, 2, 0));       // 1c lw  x6,0(x2)
    emit(ad(7, 0, 18));            // 20
    emit(es(0, 7, 2, 1));          // 24 sb  x7,1(x2)
    emit(ei(3, 8, 2, 2, 0));       // 28 lw
    emit(ei(3, 9, 5, 2, 2));       // 2c lhu x9,2(x2)
    emit(ei(3, 10, 1, 2, 2));      // 30 lh  x10,2(x2)
    emit(es(1, 7, 2, 2));          // 34 sh  x7,2(x2)
    emit(ei(3, 11, 2, 2, 0));      // 38 lw
    emit(es(2, 1, 2, 4));          // 3c sw  x1,4(x2)
    emit(ei(3, 13, 2, 2, 0));      // 40 lw  x13,0(x2)
    emit(ei(3, 14, 2, 2, 4));      // 44 lw  x14,4(x2)
    tick(2);
    rst = 1'b0;
    tick(18);
    chk("lb", rg(3), 32'hFFFF_FFFF);
    chk("lbu", rg(4), 32'h0000_0080);
    chk("lh", rg(5), 32'h0000_00FF);
    chk("lw", rg(6), 32'h8000_00FF);
    chk("sb_lw", rg(8), 32'h8000_12FF);
    chk("lhu_hi", rg(9), 32'h0000_8000);
    chk("lh_hi", rg(10), 32'hFFFF_8000);
    chk("sh_lw", rg(11), 32'h0012_12FF);
    chk("sw_neigh", rg(13), 32'h0012_12FF);
    chk("sw_next", rg(14), 32'h8000_00FF);

    // ---------------- program 4: riscv-tests style pass/fail ----------------
    rst = 1'b1;
    clr_rom();
    emit(ad(3, 0, 2));           // 00 test number
    emit(ad(10, 0, 5));          // 04
    emit(ad(11, 0, 0));          // 08
    emit(er(0, 10, 11, 0, 11));  // 0c add x11,x11,x10
    emit(ad(10, 10, -1));        // 10
    emit(eb(1, 10, 0, -8));      // 14 bne x10,x0,-8
    emit(ad(12, 0, 15));         // 18
    emit(eb(1, 11, 12, 16));     // 1c bne x11,x12 -> fail
    emit(ad(27, 0, 1));          // 20 pass
    emit(ad(26, 0, 1));          // 24
    emit(ej(0, 0));              // 28 spin
    emit(ad(27, 0, 0));          // 2c fail
    emit(ad(26, 0, 1));          // 30
    emit(ej(0, 0));              // 34 spin
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick(1);
      if (rg(26) === 32'd1) break;
    end
    chk("done_x26", rg(26), 32'd1);
    tick(20);
    chk("pass_x27", rg(27), 32'd1);
    chk("test_x3", rg(3), 32'd2);
    chk("loop_sum", rg(11), 32'd15);
    chk("spin_pc", pc(), 32'h28);

    // reset during the spin loop restarts the program
    rst = 1'b1;
    tick(1);
    chk("rst3_pc", pc(), 32'h0);
    chk("rst3_x26", rg(26), 32'h0);
    chk("rst3_x27", rg(27), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("restart_pc", pc(), 32'h4);
    chk("restart_x3", rg(3), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/open_riscv_soc.md
Name: open_riscv_soc

Overview:
- Minimal RV32I system-on-chip: single-cycle integer core, instruction ROM, data RAM.
- Only external connections are clock and reset.
- Executes riscv-tests style programs (rv32ui-p) preloaded into ROM by the bench.
- Pass/fail is reported through the register file: x3 = test number, x26 = 1 when finished, x27 = 1 for pass / 0 for fail.
- Required hierarchy, because benches probe it:
  - core instance open_risc_v_inst, containing register-file instance regs_inst with array regs[0:31] of 32 bits;
  - ROM instance rom_inst, containing array rom_mem of 32-bit words.

Parameters:
- ROM_DEPTH, 4096, ROM size in 32-bit words; rom_mem is indexed [0:ROM_DEPTH-1].
- RAM_DEPTH, 4096, data RAM size in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.

Behaviour:
- Reset: on a rising clk edge with rst=1:
  - pc <= RESET_PC;
  - regs[0..31] <= 0.
  - ROM and RAM contents are not touched.
  - Reset asserted mid-program aborts the program and restarts fetch at RESET_PC on the first edge after rst falls.
- Fetch:
  - Instruction is read combinationally as rom_mem[pc[13:2]]; pc[1:0] is ignored.
  - ROM is loaded only by $readmemh, with one 32-bit hex word per line.
- Single cycle per instruction: decode, execute and writeback complete in one clock.
  - PC, register write and store all commit on the same rising edge.
- Register file:
  - 2 combinational read ports, 1 write port.
  - x0 always reads 0, and writes to it are discarded.
  - Read-after-write in the same cycle returns the old value; next-cycle reads see the new value.
- Supported instructions: full RV32I base:
  - LUI, AUIPC, JAL, JALR (target LSB cleared);
  - BEQ, BNE, BLT, BGE, BLTU, BGEU;
  - LB, LH, LW, LBU, LHU; SB, SH, SW;
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic rules:
  - All arithmetic is 32-bit modulo 2^32; overflow wraps silently.
  - Shift amount is rs2[4:0] or shamt[4:0].
  - SLT is signed, SLTU is unsigned; SRA sign-fills.
- Immediates: sign-extended per RISC-V format.
  - Branch and JAL offsets are relative to the current instruction's pc.
- Next PC:
  - pc+4 by default;
  - the branch/jump target when taken;
  - JAL and JALR write pc+4 to rd.
- Data RAM:
  - Byte-addressed, word-organised, indexed by addr[13:2].
  - Loads read combinationally; sub-word loads select the lane by addr[1:0], then sign- or zero-extend.
  - Stores use byte enables: SB writes one lane, SH writes two lanes per addr[1], SW writes all four.
  - Misaligned accesses are not trapped: lane selection uses the low address bits, and the result is undefined but must not affect other state.
- FENCE, ECALL, EBREAK, CSR* and any unrecognised opcode execute as NOP:
  - pc+4, no register or memory write.
- No interrupts, no exceptions, no stall or handshake logic.

Decomposition:
- Shared package open_riscv_pkg holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE);
  - funct3/funct7 constants;
  - ALU operation enum.
- Natural sub-modules, with required instance names:
  - open_risc_v (core) as open_risc_v_inst, which contains regs (register file) as regs_inst;
  - rom as rom_inst;
  - ram as ram_inst.
- Decode and ALU stay inside the core.

Test Plan:
- Reset: hold rst=1 for 2 edges, then release.
  - Expect pc = 0 and all regs = 0.
  - The first instruction executes on the first edge after release.
- ALU program: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; sltu x5,x1,x2; sra x6,x2,1.
  - Expect x3=2, x4=0xFFFFFFF8, x5=1, x6=0xFFFFFFFE.
- x0 and immediates:
  - addi x0,x0,7 → x0 stays 0.
  - lui x7,0x80000; addi x7,x7,-1 → x7=0x7FFFFFFF.
  - auipc x8,1 at pc 0x20 → x8=0x1020.
- Control flow:
  - Taken bne skips the next instruction.
  - jal x1,+8 at pc 0x10 → x1=0x14, pc=0x18.
  - jalr x0,0(x1) with x1=0x15 → pc=0x14.
  - Untaken beq falls through.
- Memory: sw 0x8000_00FF to addr 0x100; then lb from 0x100, lbu from 0x103, lh from 0x100, lw from 0x100.
  - Expect 0xFFFFFFFF, 0x80, 0x000000FF, 0x800000FF respectively.
  - Then sb 0x12 to 0x101 → lw gives 0x800012FF.
- Compliance flow: load rv32ui-p-add hex into rom_mem and run.
  - Expect x26 becomes 1, and 200 ns later x27 = 1.
  - Repeat for every rv32ui-p program, with a timeout of 100k cycles per program.
